// File: rtl/axi_resp_pkg.sv
// Response codes shared by the write- and read-response subordinates of the tiny AXI bus.
package axi_resp_pkg;
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? BRESP_SLVERR : BRESP_OKAY;
  endfunction
endpackage

// File: rtl/wresp_chan_subo_q_if.sv
// Bundle of the request-tracking, write-completion and B-channel signals of wresp_chan_subo_q.
interface wresp_chan_subo_q_if #(
  parameter int ID_W = 4
);
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bcomp;
  logic            reqc_s_valid;
  logic [ID_W-1:0] reqc_s_id;
  logic            reqc_s_ready;
  logic            finish_swd;
  logic            finish_err;
  logic            proto_err;

  modport slave (
    input  bready, reqc_s_valid, reqc_s_id, finish_swd, finish_err,
    output bvalid, bid, bresp, bcomp, reqc_s_ready, proto_err
  );

  modport master (
    output bready, reqc_s_valid, reqc_s_id, finish_swd, finish_err,
    input  bvalid, bid, bresp, bcomp, reqc_s_ready, proto_err
  );
endinterface

// File: rtl/wresp_id_queue.sv
// In-order ID queue with three wrap-bit pointers: enqueue (wr), finish (done) and response pop (rd).
module wresp_id_queue #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  logic [ID_W-1:0] enq_id,
  input  logic            finish,
  input  logic            finish_err,
  input  logic            deq,
  output logic [AW:0]     pend_cnt,
  output logic [AW:0]     resp_cnt,
  output logic [AW:0]     occ_cnt,
  output logic            full,
  output logic [ID_W-1:0] head_id,
  output logic            head_err
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ID_W-1:0] ids  [DEPTH];
  logic            errs [DEPTH];
  logic [AW:0]     wr_ptr, done_ptr, rd_ptr;
  logic            enq_ok, finish_ok, deq_ok;

  assign pend_cnt = wr_ptr - done_ptr;
  assign resp_cnt = done_ptr - rd_ptr;
  assign occ_cnt  = wr_ptr - rd_ptr;
  assign full     = (occ_cnt == FULL_CNT);

  // Enqueue and finish can never hit the same slot: that needs pend 0 (finish blocked) or full (enqueue blocked).
  assign enq_ok    = enq && !full;
  assign finish_ok = finish && (pend_cnt != '0);
  assign deq_ok    = deq && (resp_cnt != '0);

  assign head_id  = ids[rd_ptr[AW-1:0]];
  assign head_err = errs[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      done_ptr <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ids[i]  <= '0;
        errs[i] <= 1'b0;
      end
    end else begin
      if (enq_ok) begin
        ids[wr_ptr[AW-1:0]] <= enq_id;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (finish_ok) begin
        errs[done_ptr[AW-1:0]] <= finish_err;
        done_ptr               <= done_ptr + 1'b1;
      end
      if (deq_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/wresp_chan_subo_q.sv
// Queued write-response subordinate: tracks up to DEPTH outstanding writes and answers on B in request order.
module wresp_chan_subo_q
  import axi_resp_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  wresp_chan_subo_q_if.slave     bus
);
  logic [AW:0]     pend_cnt, resp_cnt, occ_cnt;
  logic            full;
  logic [ID_W-1:0] head_id;
  logic            head_err;
  logic            proto_err;

  wresp_id_queue #(
    .ID_W  (ID_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .enq        (bus.reqc_s_valid),
    .enq_id     (bus.reqc_s_id),
    .finish     (bus.finish_swd),
    .finish_err (bus.finish_err),
    .deq        (bus.bready),
    .pend_cnt   (pend_cnt),
    .resp_cnt   (resp_cnt),
    .occ_cnt    (occ_cnt),
    .full       (full),
    .head_id    (head_id),
    .head_err   (head_err)
  );

  // All outputs decode registered queue state only; bready and reqc_s_valid never reach them combinationally.
  assign bus.bvalid       = (resp_cnt != '0);
  assign bus.bid          = head_id;
  assign bus.bresp        = resp_code(head_err);
  assign bus.bcomp        = (bus.bresp == BRESP_OKAY);
  assign bus.reqc_s_ready = !full;
  assign bus.proto_err    = proto_err;

  // Judged on the start-of-cycle pending count, so a same-cycle enqueue does not excuse a stray finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (bus.finish_swd && (pend_cnt == '0)) begin
      proto_err <= 1'b1;
    end
  end

  logic unused_occ;
  assign unused_occ = ^occ_cnt;
endmodule

// File: tb/tb_wresp_chan_subo_q.sv
// Directed bench for wresp_chan_subo_q (DEPTH 4): vector table plus hand-written corner sequences.
module tb_wresp_chan_subo_q;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  wresp_chan_subo_q_if #(.ID_W(4)) bus ();

  wresp_chan_subo_q #(.ID_W(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rv;
    logic [3:0] rid;
    logic       fs;
    logic       fe;
    logic       br;
    logic       e_bv;
    logic [3:0] e_bid;
    logic [1:0] e_br;
    logic       e_rdy;
    logic       e_pe;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_in();
    bus.reqc_s_valid = 1'b0;
    bus.reqc_s_id    = 4'h0;
    bus.finish_swd   = 1'b0;
    bus.finish_err   = 1'b0;
    bus.bready       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic enq(input logic [3:0] id);
    bus.reqc_s_valid = 1'b1;
    bus.reqc_s_id    = id;
    tick();
  endtask

  task automatic check_b(input string name, input logic bv, input logic [3:0] id, input logic [1:0] rsp);
    check({name, ".bvalid"}, 32'(bus.bvalid), 32'(bv));
    if (bv) begin
      check({name, ".bid"},   32'(bus.bid),   32'(id));
      check({name, ".bresp"}, 32'(bus.bresp), 32'(rsp));
      check({name, ".bcomp"}, 32'(bus.bcomp), 32'(rsp == 2'b00));
    end
  endtask

  initial begin
    clear_in();
    // rv rid fs fe br | bv bid bresp rdy pe   (outputs after the edge)
    vec[0]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b1, 1'b0};
    vec[1]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1,  1'b1, 4'h3, 2'b00, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b0, 4'h0, 2'b00, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b1, 1'b0};
    vec[5]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b1, 1'b0};
    vec[6]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1,  1'b1, 4'h1, 2'b00, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1,  1'b1, 4'h2, 2'b10, 1'b1, 1'b0};
    vec[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1,  1'b1, 4'h3, 2'b00, 1'b1, 1'b0};
    vec[11] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1,  1'b1, 4'h4, 2'b10, 1'b1, 1'b0};
    vec[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b0, 4'h0, 2'b00, 1'b1, 1'b0};
    vec[13] = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b0,  1'b0, 4'h0, 2'b00, 1'b1, 1'b1};
    vec[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0,  1'b1, 4'h7, 2'b00, 1'b1, 1'b1};
    vec[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1,  1'b0, 4'h0, 2'b00, 1'b1, 1'b1};

    do_reset();
    check("rst.bvalid", 32'(bus.bvalid), 32'd0);
    check("rst.bid",    32'(bus.bid),    32'd0);
    check("rst.bresp",  32'(bus.bresp),  32'd0);
    check("rst.bcomp",  32'(bus.bcomp),  32'd1);
    check("rst.ready",  32'(bus.reqc_s_ready), 32'd1);
    check("rst.proto",  32'(bus.proto_err),    32'd0);

    for (int i = 0; i < NV; i++) begin
      bus.reqc_s_valid = vec[i].rv;
      bus.reqc_s_id    = vec[i].rid;
      bus.finish_swd   = vec[i].fs;
      bus.finish_err   = vec[i].fe;
      bus.bready       = vec[i].br;
      tick();
      check_b($sformatf("vec%0d", i), vec[i].e_bv, vec[i].e_bid, vec[i].e_br);
      check($sformatf("vec%0d.ready", i), 32'(bus.reqc_s_ready), 32'(vec[i].e_rdy));
      check($sformatf("vec%0d.proto", i), 32'(bus.proto_err),    32'(vec[i].e_pe));
    end

    // Backpressure: head stays put for 5 stalled cycles while a second write queues behind it.
    do_reset();
    enq(4'h9);
    bus.finish_swd = 1'b1; bus.finish_err = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bus.reqc_s_valid = 1'b1; bus.reqc_s_id = 4'hA; end
      if (i == 2) begin bus.finish_swd = 1'b1; bus.finish_err = 1'b0; end
      check_b($sformatf("stall%0d", i), 1'b1, 4'h9, 2'b10);
      tick();
    end
    check_b("stall_end", 1'b1, 4'h9, 2'b10);
    bus.bready = 1'b1;
    tick();
    check_b("bp_second", 1'b1, 4'hA, 2'b00);
    bus.bready = 1'b1;
    tick();
    check_b("bp_drained", 1'b0, 4'h0, 2'b00);

    // Simultaneous enqueue/finish/pop on a full queue with one finished entry.
    do_reset();
    for (int i = 1; i <= 4; i++) enq(4'(i));
    bus.finish_swd = 1'b1;
    tick();
    check("sim.full_ready", 32'(bus.reqc_s_ready), 32'd0);
    check_b("sim.pre", 1'b1, 4'h1, 2'b00);
    bus.reqc_s_valid = 1'b1; bus.reqc_s_id = 4'hE;
    bus.finish_swd = 1'b1; bus.bready = 1'b1;
    tick();
    check_b("sim.post", 1'b1, 4'h2, 2'b00);
    check("sim.ready", 32'(bus.reqc_s_ready), 32'd1);
    bus.finish_swd = 1'b1; bus.finish_err = 1'b1; bus.bready = 1'b1;
    tick();
    check_b("sim.d3", 1'b1, 4'h3, 2'b10);
    bus.finish_swd = 1'b1; bus.bready = 1'b1;
    tick();
    check_b("sim.d4", 1'b1, 4'h4, 2'b00);
    bus.bready = 1'b1;
    tick();
    check_b("sim.empty", 1'b0, 4'h0, 2'b00);
    bus.finish_swd = 1'b1;
    tick();
    check("sim.no_ghost_enq", 32'(bus.proto_err), 32'd1);
    check("sim.no_ghost_bv",  32'(bus.bvalid),    32'd0);

    // Reset mid-flight: asynchronous assertion clears outputs before any clock edge.
    do_reset();
    bus.finish_swd = 1'b1;
    tick();
    check("mid.proto_set", 32'(bus.proto_err), 32'd1);
    enq(4'h1); enq(4'h2); enq(4'h3);
    bus.finish_swd = 1'b1;
    tick();
    check_b("mid.pre", 1'b1, 4'h1, 2'b00);
    #3;
    rst = 1'b1;
    #1;
    check("mid.bvalid", 32'(bus.bvalid),       32'd0);
    check("mid.ready",  32'(bus.reqc_s_ready), 32'd1);
    check("mid.proto",  32'(bus.proto_err),    32'd0);
    check("mid.bid",    32'(bus.bid),          32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.finish_swd = 1'b1;
    tick();
    check("mid.ptrs_empty", 32'(bus.proto_err), 32'd1);
    check("mid.no_bvalid",  32'(bus.bvalid),    32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/wresp_chan_subo_q.md
# wresp_chan_subo_q

Parametrised, queued write-response channel subordinate for the tiny AXI bus logic. It records the ID of every accepted write request in an in-order tracking queue and pairs each with a completion event from the write-data side. It then drives the B channel (bvalid/bid/bresp) one response per completion, strictly in request order. Unlike the single-outstanding version, it supports up to DEPTH outstanding writes, configurable ID width, and per-write error status.

## Interface
Parameters:
- ID_W, 4, width of bid / reqc_s_id
- DEPTH, 4, max outstanding writes; power of two, >= 2
- AW, log2(DEPTH), pointer index width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- bvalid  out  1  B-channel response valid
- bready  in  1  B-channel ready from manager
- bid  out  ID_W  response ID
- bresp  out  2  response code: 2'b00 OKAY, 2'b10 SLVERR
- bcomp  out  1  legacy completion flag = (bresp == OKAY)
- reqc_s_valid  in  1  write request accepted on address channel
- reqc_s_id  in  ID_W  ID of that request
- reqc_s_ready  out  1  tracking queue not full
- finish_swd  in  1  one-cycle pulse: oldest unfinished write's data complete
- finish_err  in  1  qualifies finish_swd: 1 = SLVERR
- proto_err  out  1  sticky: finish_swd with no unfinished write

## Operation
- Storage: DEPTH entries of {id[ID_W-1:0], err}; three AW+1-bit pointers wr_ptr, done_ptr, rd_ptr (extra MSB for wrap).
- pend_cnt = wr_ptr - done_ptr (queued, not yet finished); resp_cnt = done_ptr - rd_ptr (finished, awaiting B handshake); occupancy = wr_ptr - rd_ptr.
- Enqueue: reqc_s_valid && reqc_s_ready -> entry[wr_ptr].id <= reqc_s_id, wr_ptr++. reqc_s_valid while !reqc_s_ready is ignored; upstream holds.
- Finish: finish_swd && pend_cnt != 0 (value at start of cycle) -> entry[done_ptr].err <= finish_err, done_ptr++.
- finish_swd with pend_cnt == 0 -> ignored, proto_err <= 1, cleared only by rst. Applies even if a request enqueues in the same cycle.
- Response: bvalid = (resp_cnt != 0). bid = entry[rd_ptr].id; bresp = entry[rd_ptr].err ? 2'b10 : 2'b00.
- bvalid && bready -> rd_ptr++. bready while !bvalid has no effect.
- Once asserted, bvalid, bid and bresp hold stable until handshake.
- All three events (enqueue, finish, B handshake) may occur in the same cycle and are each applied independently.
- reqc_s_ready = (occupancy != DEPTH), combinational from registers. A B handshake in the full cycle does not raise ready until the next cycle.
- Pointer arithmetic is modulo 2^(AW+1); entry index = ptr[AW-1:0].

## Timing
- Reset (async assert, sync-to-clk release by the system) sets:
  - all pointers 0; all entries {0,0}
  - bvalid 0, bid 0, bresp 2'b00, bcomp 1, reqc_s_ready 1, proto_err 0
- Reset mid-operation discards all outstanding writes; bvalid drops immediately.
- Latencies:
  - reqc_s_valid to finish_swd: earliest the following cycle.
  - finish_swd at edge N -> bvalid high after edge N (one cycle, same as single-outstanding version).
  - Back-to-back B responses: one per cycle with bready held high.
  - Full throughput is sustained with DEPTH >= 2.
- No combinational path from bready or reqc_s_valid to any output.

## Structure
- Shared package axi_resp_pkg: BRESP_OKAY = 2'b00, BRESP_SLVERR = 2'b10; also reused by the read-response side.
- One natural sub-module: wresp_id_queue holds the entry array and three pointers, with ports enq/finish/deq and counts. The top level adds B-channel decode and proto_err.
- No state machine beyond the pointers; bvalid is derived from resp_cnt.

## Test plan
- Single write: reset, enqueue id 4'h3, finish_swd (err 0) next cycle, bready 1 -> bvalid 1 for one cycle one cycle after finish, bid 3, bresp 00, bcomp 1.
- Fill and stall (DEPTH 4):
  - Enqueue ids 1,2,3,4, none finished -> reqc_s_ready 0, bvalid 0; a 5th request is ignored.
  - Finish all with err pattern 0,1,0,1, bready 1 -> bid 1,2,3,4 on consecutive cycles, bresp 00,10,00,10.
- Backpressure: one finished response, bready held 0 for 5 cycles -> bvalid, bid, bresp stable.
  - Second finish during the stall is queued and presented the cycle after the first handshake.
- Simultaneous events: full queue with resp_cnt 1; in one cycle pulse enqueue, finish and bready -> head pops.
  - The enqueue is ignored (ready was 0); the finish applies; reqc_s_ready is 1 next cycle.
- Protocol error: finish_swd with empty queue, concurrent with enqueue of id 7 -> proto_err 1, no bvalid.
  - id 7 stays pending until a later finish.
- Reset mid-flight: 3 outstanding, bvalid high; assert rst mid-cycle -> bvalid 0 immediately, reqc_s_ready 1, pointers 0, proto_err 0.
